clause_1: RTL and testbench

- One clause storage/evaluation unit for the SAT-bin engine, covering NUM_VARS_A_BIN variables of the bin.
- A write captures the clause's literal pattern.
- It then evaluates the clause combinationally against the current variable assignment from the base: satisfied, free-literal count, unit implication, conflict.
- It drives implied and conflict values back toward the base.

---
 rtl/clause_1_pkg.sv | 20 ++
 rtl/clause_1_lit.sv | 46 ++++
 rtl/clause_1.sv | 72 +++++++
 tb/tb_clause_1.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/clause_1_pkg.sv
// Shared encodings for the SAT-bin clause unit: variable values, literal codes, slot width.
// Constants only; no timing or backpressure.
package clause_1_pkg;

  localparam int SLOT_W = 3;

  typedef enum logic [1:0] {
    FREE     = 2'b00,
    VAL1     = 2'b01,
    VAL2     = 2'b10,
    CONFLICT = 2'b11
  } value_e;

  typedef enum logic [1:0] {
    LIT_NONE = 2'b00,
    LIT_POS  = 2'b01,
    LIT_NEG  = 2'b10
  } lit_e;

endpackage

// File: rtl/clause_1_lit.sv
// clause_lit_cell: one stored literal, its true/free/false classification and its slot drive.
// Literal updates on the write edge; classification and drive are zero-latency; no backpressure.
module clause_lit_cell
  import clause_1_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [SLOT_W-1:0] slot_in,
  input  logic              imp_en,
  input  logic              conf_en,
  output logic              is_true,
  output logic              is_free,
  output logic              is_false,
  output logic [SLOT_W-1:0] drive
);

  logic [1:0] lit;
  logic [1:0] value;
  logic       present;

  // The implied bit of the incoming slot is not part of the stored literal.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lit <= LIT_NONE;
    end else if (wr) begin
      lit <= slot_in[2:1];
    end
  end

  assign value    = slot_in[2:1];
  assign present  = (lit != LIT_NONE);
  assign is_true  = present && (value == lit);
  assign is_free  = present && (value == FREE);
  assign is_false = present && !is_true && !is_free;

  always_comb begin
    drive = '0;
    if (imp_en && is_free) begin
      drive = {lit, 1'b1};
    end else if (conf_en && present) begin
      drive = {CONFLICT, slot_in[0]};
    end
  end

endmodule

// File: rtl/clause_1.sv
// clause_1: stores one clause over a bin's variables and evaluates it against the base assignment.
// Zero-latency evaluation (pattern/length registered on wr_i); no backpressure, outputs gated by backtrack.
module clause_1
  import clause_1_pkg::*;
#(
  parameter int NUM_VARS_A_BIN = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_i,
  input  logic [SLOT_W*NUM_VARS_A_BIN-1:0]   var_value_frombase_i,
  output logic [SLOT_W*NUM_VARS_A_BIN-1:0]   var_value_tobase_o,
  input  logic [4:0]                         clause_len_i,
  output logic [4:0]                         clause_len_o,
  input  logic                               apply_backtrack_i
);

  localparam int CNT_W = $clog2(NUM_VARS_A_BIN + 1);

  logic [NUM_VARS_A_BIN-1:0]        lit_true;
  logic [NUM_VARS_A_BIN-1:0]        lit_free;
  logic [NUM_VARS_A_BIN-1:0]        lit_false;
  logic [SLOT_W*NUM_VARS_A_BIN-1:0] drive_all;

  logic             clausesat_0;
  logic [CNT_W-1:0] freelitcnt_0;
  logic             imp_drv_0;
  logic             cclause_drv_0;
  logic             any_lit;
  logic [4:0]       len;

  for (genvar i = 0; i < NUM_VARS_A_BIN; i++) begin : g_cell
    clause_lit_cell u_cell (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr_i),
      .slot_in  (var_value_frombase_i[SLOT_W*i +: SLOT_W]),
      .imp_en   (imp_drv_0),
      .conf_en  (cclause_drv_0),
      .is_true  (lit_true[i]),
      .is_free  (lit_free[i]),
      .is_false (lit_false[i]),
      .drive    (drive_all[SLOT_W*i +: SLOT_W])
    );
  end

  always_comb begin
    freelitcnt_0 = '0;
    for (int i = 0; i < NUM_VARS_A_BIN; i++) begin
      freelitcnt_0 = freelitcnt_0 + CNT_W'(lit_free[i]);
    end
  end

  // Every present literal is exactly one of true/free/false.
  assign any_lit       = |(lit_true | lit_free | lit_false);
  assign clausesat_0   = |lit_true;
  assign imp_drv_0     = !clausesat_0 && (freelitcnt_0 == CNT_W'(1));
  assign cclause_drv_0 = !clausesat_0 && (freelitcnt_0 == '0) && any_lit;

  assign var_value_tobase_o = apply_backtrack_i ? '0 : drive_all;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len <= '0;
    end else if (wr_i) begin
      len <= clause_len_i;
    end
  end

  assign clause_len_o = len;

endmodule

// File: tb/tb_clause_1.sv
// Scenario bench for clause_1: expectations queued at stimulus time, popped and compared on sampling.
module tb_clause_1;

  localparam int N = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_i;
  logic [3*N-1:0]  vin;
  logic [3*N-1:0]  vout;
  logic [4:0]      len_in;
  logic [4:0]      len_out;
  logic            bt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]     flags;  // {clausesat, imp, cclause}
    logic [3:0]     cnt;
    logic [3*N-1:0] out;
    logic [4:0]     len;
  } exp_t;

  exp_t sb[$];

  clause_1 #(.NUM_VARS_A_BIN(N)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .wr_i                 (wr_i),
    .var_value_frombase_i (vin),
    .var_value_tobase_o   (vout),
    .clause_len_i         (len_in),
    .clause_len_o         (len_out),
    .apply_backtrack_i    (bt)
  );

  always #5 clk = ~clk;

  function automatic logic [3*N-1:0] slot(input int i, input logic [2:0] v);
    logic [3*N-1:0] r;
    r = '0;
    r[3*i +: 3] = v;
    return r;
  endfunction

  function automatic exp_t mk(input logic s, input logic im, input logic cc, input logic [3:0] c,
                              input logic [3*N-1:0] o, input logic [4:0] l);
    exp_t e;
    e.flags = {s, im, cc};
    e.cnt   = c;
    e.out   = o;
    e.len   = l;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; wr_i = 1'b0; vin = '0; len_in = 5'd0; bt = 1'b0;
    sb.push_back(mk(0, 0, 0, 4'd0, '0, 5'd0));
    repeat (2) @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++; if ({dut.clausesat_0, dut.imp_drv_0, dut.cclause_drv_0} !== e.flags) begin errors++; $display("FAIL reset_flags got=%b exp=%b", {dut.clausesat_0, dut.imp_drv_0, dut.cclause_drv_0}, e.flags); end
    checks++; if (vout !== e.out) begin errors++; $display("FAIL reset_out got=%h exp=%h", vout, e.out); end
    checks++; if (len_out !== e.len) begin errors++; $display("FAIL reset_len got=%0d exp=%0d", len_out, e.len); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write();
    exp_t e;
    @(negedge clk);
    vin = slot(1, 3'b010) | slot(3, 3'b100) | slot(5, 3'b100);
    len_in = 5'd3; wr_i = 1'b1;
    sb.push_back(mk(1, 0, 0, 4'd0, '0, 5'd3));
    @(posedge clk); #1;
    wr_i = 1'b0;
    @(negedge clk);
    e = sb.pop_front();
    checks++; if ({dut.clausesat_0, dut.imp_drv_0, dut.cclause_drv_0} !== e.flags) begin errors++; $display("FAIL write_flags got=%b exp=%b", {dut.clausesat_0, dut.imp_drv_0, dut.cclause_drv_0}, e.flags); end
    checks++; if (dut.freelitcnt_0 !== e.cnt) begin errors++; $display("FAIL write_cnt got=%0d exp=%0d", dut.freelitcnt_0, e.cnt); end
    checks++; if (vout !== e.out) begin errors++; $display("FAIL write_out got=%h exp=%h", vout, e.out); end
    checks++; if (len_out !== e.len) begin errors++; $display("FAIL write_len got=%0d exp=%0d", len_out, e.len); end
  endtask

  task automatic test_eval(input string name, input logic [3*N-1:0] v, input logic b, input exp_t ex);
    exp_t e;
    @(negedge clk);
    vin = v; bt = b;
    sb.push_back(ex);
    #1;
    e = sb.pop_front();
    checks++; if ({dut.clausesat_0, dut.imp_drv_0, dut.cclause_drv_0} !== e.flags) begin errors++; $display("FAIL %s_flags got=%b exp=%b", name, {dut.clausesat_0, dut.imp_drv_0, dut.cclause_drv_0}, e.flags); end
    checks++; if (dut.freelitcnt_0 !== e.cnt) begin errors++; $display("FAIL %s_cnt got=%0d exp=%0d", name, dut.freelitcnt_0, e.cnt); end
    checks++; if (vout !== e.out) begin errors++; $display("FAIL %s_out got=%h exp=%h", name, vout, e.out); end
    checks++; if (len_out !== e.len) begin errors++; $display("FAIL %s_len got=%0d exp=%0d", name, len_out, e.len); end
    bt = 1'b0;
  endtask

  task automatic test_write_same_cycle();
    exp_t e;
    @(negedge clk);
    vin = slot(2, 3'b010); len_in = 5'd1; wr_i = 1'b1;
    // Before the edge the old clause (vars 1,3,5) sees all three vars free.
    sb.push_back(mk(0, 0, 0, 4'd3, '0, 5'd3));
    sb.push_back(mk(1, 0, 0, 4'd0, '0, 5'd1));
    #1;
    e = sb.pop_front();
    checks++; if (dut.freelitcnt_0 !== e.cnt) begin errors++; $display("FAIL prewrite_cnt got=%0d exp=%0d", dut.freelitcnt_0, e.cnt); end
    checks++; if (len_out !== e.len) begin errors++; $display("FAIL prewrite_len got=%0d exp=%0d", len_out, e.len); end
    @(posedge clk); #1;
    wr_i = 1'b0;
    e = sb.pop_front();
    checks++; if ({dut.clausesat_0, dut.imp_drv_0, dut.cclause_drv_0} !== e.flags) begin errors++; $display("FAIL postwrite_flags got=%b exp=%b", {dut.clausesat_0, dut.imp_drv_0, dut.cclause_drv_0}, e.flags); end
    checks++; if (dut.freelitcnt_0 !== e.cnt) begin errors++; $display("FAIL postwrite_cnt got=%0d exp=%0d", dut.freelitcnt_0, e.cnt); end
    checks++; if (len_out !== e.len) begin errors++; $display("FAIL postwrite_len got=%0d exp=%0d", len_out, e.len); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    @(negedge clk);
    vin = slot(2, 3'b000) | slot(1, 3'b100); len_in = 5'd9;
    #2;
    rst = 1'b1;
    sb.push_back(mk(0, 0, 0, 4'd0, '0, 5'd0));
    #1;
    e = sb.pop_front();
    checks++; if ({dut.clausesat_0, dut.imp_drv_0, dut.cclause_drv_0} !== e.flags) begin errors++; $display("FAIL arst_flags got=%b exp=%b", {dut.clausesat_0, dut.imp_drv_0, dut.cclause_drv_0}, e.flags); end
    checks++; if (dut.freelitcnt_0 !== e.cnt) begin errors++; $display("FAIL arst_cnt got=%0d exp=%0d", dut.freelitcnt_0, e.cnt); end
    checks++; if (vout !== e.out) begin errors++; $display("FAIL arst_out got=%h exp=%h", vout, e.out); end
    checks++; if (len_out !== e.len) begin errors++; $display("FAIL arst_len got=%0d exp=%0d", len_out, e.len); end
    @(negedge clk);
    rst = 1'b0;
    // With no clause stored, any input pattern leaves everything quiet.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vin = 24'($urandom);
      sb.push_back(mk(0, 0, 0, 4'd0, '0, 5'd0));
      #1;
      e = sb.pop_front();
      checks++; if (dut.freelitcnt_0 !== e.cnt || vout !== e.out || {dut.clausesat_0, dut.imp_drv_0, dut.cclause_drv_0} !== e.flags) begin
        errors++; $display("FAIL empty_%0d cnt=%0d out=%h flags=%b exp cnt=%0d out=%h flags=%b", k, dut.freelitcnt_0, vout, {dut.clausesat_0, dut.imp_drv_0, dut.cclause_drv_0}, e.cnt, e.out, e.flags);
      end
    end
  endtask

  initial begin
    logic [3*N-1:0] imp_in;
    imp_in = slot(1, 3'b100) | slot(5, 3'b010);
    test_reset();
    test_write();
    test_eval("allfree", '0, 1'b0, mk(0, 0, 0, 4'd3, '0, 5'd3));
    test_eval("imp", imp_in, 1'b0, mk(0, 1, 0, 4'd1, slot(3, 3'b101), 5'd3));
    test_eval("conflict", imp_in | slot(3, 3'b111), 1'b0,
              mk(0, 0, 1, 4'd0, slot(1, 3'b110) | slot(3, 3'b111) | slot(5, 3'b110), 5'd3));
    test_eval("conf_impbits", slot(1, 3'b101) | slot(3, 3'b111) | slot(5, 3'b011) | slot(0, 3'b111), 1'b0,
              mk(0, 0, 1, 4'd0, slot(1, 3'b111) | slot(3, 3'b111) | slot(5, 3'b111), 5'd3));
    test_eval("backtrack", imp_in, 1'b1, mk(0, 1, 0, 4'd1, '0, 5'd3));
    test_eval("sat_one", slot(1, 3'b010), 1'b0, mk(1, 0, 0, 4'd2, '0, 5'd3));
    test_write_same_cycle();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
